uart_rx_bps: RTL and testbench

//   UART 8N1 serial receiver, the receive end of the baud-clocked serial link.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_rx_bps.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_bps.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx_bps receiver: FSM state encoding and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // 100 MHz clock at 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period cycle counter for the UART receiver: clears on request, wraps at the end of
// each bit period, and strobes at half and full period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic srst_i,
    input  logic clear_i,
    output logic half_o,
    output logic full_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign half_o = (cnt_q == HALF_CNT);
    assign full_o = (cnt_q == FULL_CNT);

    // Wrapping at the full-period value keeps the count inside its range in every state.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || full_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_bps.sv
// UART receiver with centre sampling, one-entry holding register and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_bps
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);
    localparam int BW = $clog2(DATA_BITS + 1);

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d, oe_q, oe_d, pe_q, pe_d;
    logic                 rx_s, fall, tmr_clear, half, full, par_bad;

    assign rx_s = sync2_q;
    assign fall = prev_q & ~rx_s;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .srst_i  (rst_n),
        .clear_i (tmr_clear),
        .half_o  (half),
        .full_o  (full)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_bad = (par_q != ((^shreg_q) ^ PARITY_ODD));
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        oe_d      = 1'b0;
        pe_d      = 1'b0;
        tmr_clear = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif
        if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                tmr_clear = 1'b1;
                if (fall) begin
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (half) begin
                    tmr_clear = 1'b1;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (full) begin
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (full) begin
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Error priority: framing, then parity, then overrun.
                if (full) begin
                    state_d = S_IDLE;
                    if (!rx_s) begin
                        fe_d = 1'b1;
                    end else if (par_bad) begin
                        pe_d = 1'b1;
                    end else if (valid_q && !rx_ack) begin
                        oe_d = 1'b1;
                    end else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
            pe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            oe_q      <= oe_d;
            pe_q      <= pe_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_err   = fe_q;
    assign overrun_err = oe_q;
    assign parity_err  = pe_q;

endmodule

// File: tb/tb_uart_rx_bps.sv
// Scoreboard bench for uart_rx_bps at 16 clocks per bit; parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_bps;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rxd = 1'b1;
    logic          rx_ack = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, busy, frame_err, overrun_err, parity_err;

    always #5 clk = ~clk;

    uart_rx_bps #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    typedef enum int {EV_VALID, EV_FRAME, EV_OVERRUN, EV_PARITY} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic pop(input ev_e k, input logic [7:0] d);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got %s data %0h required no event", k.name(), d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || (k == EV_VALID && e.data !== d)) begin
                bad++;
                $display("FAIL sb_event: got %s/%0h required %s/%0h", k.name(), d, e.kind.name(), e.data);
            end else begin
                $display("ok   sb %s data %0h", k.name(), d);
            end
        end
    endtask

    // Monitor: every error pulse or holding-register load must match the next expected event.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (frame_err)   pop(EV_FRAME, 8'h00);
            if (overrun_err) pop(EV_OVERRUN, 8'h00);
            if (parity_err)  pop(EV_PARITY, 8'h00);
            if (rx_valid && (!prev_valid || rx_data != prev_data)) begin
                valid_cyc = cyc;
                pop(EV_VALID, rx_data);
            end
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
    end

    // Drives one frame; with ack_done, rx_ack is high in the stop-bit sample cycle.
    task automatic send(input logic [7:0] d, input logic stop_bit, input logic use_par,
                        input logic par_bit, input bit ack_done);
        logic [10:0] bits;
        int nb;
        int ack_c;
        bits  = use_par ? {stop_bit, par_bit, d, 1'b0} : {1'b0, stop_bit, d, 1'b0};
        nb    = use_par ? 11 : 10;
        ack_c = 10 + CPB * (nb - 1);
        start_cyc = cyc + 1;
        for (int c = 0; c < nb * CPB; c++) begin
            rxd    = bits[c / CPB];
            rx_ack = ack_done && (c == ack_c);
            @(posedge clk); #1;
        end
        rxd    = 1'b1;
        rx_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ff_byte;
        logic [9:0] ff_bits;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rx_data, rx_valid, busy, frame_err, overrun_err, parity_err}, 0);
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 1: plain byte, latency from start edge
        sb.push_back('{EV_VALID, 8'hA5});
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        lat = valid_cyc - start_cyc;
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1);
        check("a5_latency_in_153_155", (lat >= 153 && lat <= 155), 1);
        ack_pulse();
        check("ack_clears_valid", rx_valid, 0);

        // 2: short low glitch
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        check("glitch_busy_high", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_low", busy, 0);
        check("glitch_no_valid", rx_valid, 0);

        // 3: stop bit forced low
        sb.push_back('{EV_FRAME, 8'h00});
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("frame_no_valid", rx_valid, 0);

        // 4: overrun, then ack in completion cycle
        sb.push_back('{EV_VALID, 8'h11});
        send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back('{EV_OVERRUN, 8'h00});
        send(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        check("overrun_keeps_old", rx_data, 8'h11);
        check("overrun_valid", rx_valid, 1);
        sb.push_back('{EV_VALID, 8'h22});
        send(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ack_same_cycle_data", rx_data, 8'h22);
        check("ack_same_cycle_valid", rx_valid, 1);

        // 5: reset during data bit 4 of 0xFF
        ff_byte = 8'hFF;
        ff_bits = {1'b1, ff_byte, 1'b0};
        for (int c = 0; c < 5 * CPB + 8; c++) begin
            rxd = ff_bits[c / CPB];
            @(posedge clk); #1;
        end
        check("mid_frame_busy", busy, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_frame_reset_outputs",
              {rx_data, rx_valid, busy, frame_err, overrun_err, parity_err}, 0);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sb.push_back('{EV_VALID, 8'h0F});
        send(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_reset_data", rx_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
        // 6: even parity, 0x07 needs parity bit 1
        ack_pulse();
        sb.push_back('{EV_PARITY, 8'h00});
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("parity_bad_no_valid", rx_valid, 0);
        sb.push_back('{EV_VALID, 8'h07});
        send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        check("parity_good_data", rx_data, 8'h07);
`else
        check("parity_err_tied_low", parity_err, 0);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
